// File: rtl/ldst_control_seq_if.sv
// Control bundle between the load/store sequencer and the Datapath2 control inputs.
// master = sequencer side, slave = datapath / instruction-register side.
interface ldst_control_seq_if #(
  parameter int OPC_W = 5
);
  logic             run;
  logic [OPC_W-1:0] ir_opcode;

  logic             PCout;
  logic             Zlowout;
  logic             MDRout;
  logic             MARin;
  logic             Zin;
  logic             PCin;
  logic             MDRin;
  logic             IRin;
  logic             Yin;
  logic             Read;
  logic             Write;
  logic             Gra;
  logic             Grb;
  logic             Rin;
  logic             Rout;
  logic             BAout;
  logic             Cout;
  logic [4:0]       alu_op;
  logic [3:0]       state;
  logic             done;
  logic             illegal;

  modport master (
    input  run, ir_opcode,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
    output Read, Write, Gra, Grb, Rin, Rout, BAout, Cout,
    output alu_op, state, done, illegal
  );

  modport slave (
    output run, ir_opcode,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
    input  Read, Write, Gra, Grb, Rin, Rout, BAout, Cout,
    input  alu_op, state, done, illegal
  );
endinterface

// File: rtl/ldst_control_seq.sv
// Hardwired Moore sequencer for ld/ldi/st: fetch, effective-address add and the
// memory phase, with MEM_WAIT cycles per memory access.
module ldst_control_seq #(
  parameter int               OPC_W     = 5,
  parameter int               MEM_WAIT  = 1,
  parameter logic [OPC_W-1:0] OPC_LD    = 5'd0,
  parameter logic [OPC_W-1:0] OPC_LDI   = 5'd1,
  parameter logic [OPC_W-1:0] OPC_ST    = 5'd2,
  parameter logic [4:0]       ALU_ADD   = 5'd2,
  parameter logic [4:0]       ALU_INCPC = 5'd12
) (
  input logic                clk,
  input logic                clr,
  ldst_control_seq_if.master bus
);

  localparam int               CNT_W    = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_FR   = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_T7   = 4'd9,
    S_DONE = 4'd10,
    S_ERR  = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    C_LD  = 2'd0,
    C_LDI = 2'd1,
    C_ST  = 2'd2,
    C_BAD = 2'd3
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls_q, cls_d;
  logic [4:0]       alu_q, alu_d;
  logic             last_beat;

  function automatic cls_e decode_opc(input logic [OPC_W-1:0] opc);
    cls_e c;
    if (opc == OPC_LD)       c = C_LD;
    else if (opc == OPC_LDI) c = C_LDI;
    else if (opc == OPC_ST)  c = C_ST;
    else                     c = C_BAD;
    return c;
  endfunction

  assign last_beat = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
    end
  end

  // The opcode class is only consulted after T3 has written it, so it needs no reset.
  always_ff @(posedge clk) begin
    cls_q <= cls_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    alu_d   = alu_q;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        state_d = S_FR;
        cnt_d   = '0;
      end
      S_FR: begin
        if (last_beat) state_d = S_T2;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        cls_d   = decode_opc(bus.ir_opcode);
        state_d = (cls_d == C_BAD) ? S_ERR : S_T4;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (cls_q == C_LDI) begin
          state_d = S_DONE;
        end else begin
          state_d = S_T6;
          cnt_d   = '0;
        end
      end
      S_T6: begin
        // ld waits out the memory read here; st spends one cycle loading MDR.
        if (cls_q == C_LD) begin
          if (last_beat) state_d = S_T7;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_T7;
          cnt_d   = '0;
        end
      end
      S_T7: begin
        if (cls_q == C_ST) begin
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = bus.run ? S_T0 : S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ALU code is registered so it is valid for the whole state that uses it.
    if (state_d == S_T0) alu_d = ALU_INCPC;
    if (state_d == S_T4) alu_d = ALU_ADD;
  end

  always_comb begin
    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.MARin   = 1'b0;
    bus.Zin     = 1'b0;
    bus.PCin    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.alu_op  = alu_q;
    bus.state   = state_q;

    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
      end
      S_FR: begin
        bus.Read  = 1'b1;
        bus.MDRin = last_beat;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        bus.Yin   = 1'b1;
      end
      S_T4: begin
        bus.Cout = 1'b1;
        bus.Zin  = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (cls_q == C_LDI) begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end else begin
          bus.MARin = 1'b1;
        end
      end
      S_T6: begin
        if (cls_q == C_LD) begin
          bus.Read  = 1'b1;
          bus.MDRin = last_beat;
        end else begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (cls_q == C_ST) begin
          bus.Write = 1'b1;
        end else begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
        end
      end
      S_DONE: bus.done    = 1'b1;
      S_ERR:  bus.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_control_seq.sv
// Bench for ldst_control_seq: three instances (MEM_WAIT = 1, 2, 3) share stimulus and are
// traced cycle by cycle against a micro-step list model, plus directed literal checks.
module tb_ldst_control_seq;

  localparam int N = 3;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] sig;
  } rec_t;

  localparam logic [18:0] PCO  = 19'h00001, ZLO = 19'h00002, MDO = 19'h00004, MAI = 19'h00008;
  localparam logic [18:0] ZIN  = 19'h00010, PCI = 19'h00020, MDI = 19'h00040, IRI = 19'h00080;
  localparam logic [18:0] YIN  = 19'h00100, RD  = 19'h00200, WR  = 19'h00400, GRA = 19'h00800;
  localparam logic [18:0] GRB  = 19'h01000, RIN = 19'h02000, ROUT = 19'h04000, BAO = 19'h08000;
  localparam logic [18:0] COUT = 19'h10000, DN  = 19'h20000, ILL = 19'h40000;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b0;
  logic [4:0] opc = 5'd0;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  rec_t       dut_rec [N];
  logic [4:0] dut_alu [N];

  rec_t       cur   [N];
  logic [4:0] alu_m [N];
  rec_t       mq    [N][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ldst_control_seq_if #(.OPC_W(5)) bus ();
    ldst_control_seq #(.MEM_WAIT(g + 1)) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
    );
    assign bus.run       = run;
    assign bus.ir_opcode = opc;
    assign dut_rec[g] = {bus.state, bus.illegal, bus.done, bus.Cout, bus.BAout, bus.Rout,
                         bus.Rin, bus.Grb, bus.Gra, bus.Write, bus.Read, bus.Yin, bus.IRin,
                         bus.MDRin, bus.PCin, bus.Zin, bus.MARin, bus.MDRout, bus.Zlowout,
                         bus.PCout};
    assign dut_alu[g] = bus.alu_op;
  end

  function automatic rec_t mk(input logic [3:0] st, input logic [18:0] s);
    return {st, s};
  endfunction

  // Expected micro-steps of an instruction, listed straight from the step table.
  task automatic push_fetch(input int i);
    int m = i + 1;
    mq[i].push_back(mk(4'd1, PCO | MAI | ZIN));
    mq[i].push_back(mk(4'd2, ZLO | PCI));
    for (int k = 0; k < m; k++) mq[i].push_back(mk(4'd3, RD | ((k == m - 1) ? MDI : 19'h0)));
    mq[i].push_back(mk(4'd4, MDO | IRI));
    mq[i].push_back(mk(4'd5, GRB | BAO | YIN));
  endtask

  task automatic push_tail(input int i, input logic [4:0] op);
    int m = i + 1;
    if (op > 5'd2) begin
      mq[i].push_back(mk(4'd11, ILL));
      return;
    end
    mq[i].push_back(mk(4'd6, COUT | ZIN));
    if (op == 5'd1) begin
      mq[i].push_back(mk(4'd7, ZLO | GRA | RIN));
    end else if (op == 5'd0) begin
      mq[i].push_back(mk(4'd7, ZLO | MAI));
      for (int k = 0; k < m; k++) mq[i].push_back(mk(4'd8, RD | ((k == m - 1) ? MDI : 19'h0)));
      mq[i].push_back(mk(4'd9, MDO | GRA | RIN));
    end else begin
      mq[i].push_back(mk(4'd7, ZLO | MAI));
      mq[i].push_back(mk(4'd8, GRA | ROUT | MDI));
      for (int k = 0; k < m; k++) mq[i].push_back(mk(4'd9, WR));
    end
    mq[i].push_back(mk(4'd10, DN));
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        mq[i].delete();
        cur[i]   = mk(4'd0, 19'h0);
        alu_m[i] = 5'd0;
      end else begin
        if (cur[i].st == 4'd5) push_tail(i, opc);
        if (mq[i].size() > 0) begin
          cur[i] = mq[i].pop_front();
        end else if ((cur[i].st == 4'd0 || cur[i].st == 4'd10) && run) begin
          push_fetch(i);
          cur[i] = mq[i].pop_front();
        end else begin
          cur[i] = mk(4'd0, 19'h0);
        end
        if (cur[i].st == 4'd1) alu_m[i] = 5'd12;
        if (cur[i].st == 4'd6) alu_m[i] = 5'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        nvec++;
        if (dut_rec[i] !== cur[i] || dut_alu[i] !== alu_m[i]) begin
          nerr++;
          $display("FAIL trace dut%0d t=%0t got st=%0d sig=%h alu=%0d, expected st=%0d sig=%h alu=%0d",
                   i, $time, dut_rec[i].st, dut_rec[i].sig, dut_alu[i],
                   cur[i].st, cur[i].sig, alu_m[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [4:0] op);
    opc = op;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    int d0, d1, d2, n_rd, rd_run, n_wr, n_rin, n_ill, n_dn, n_bad;
    bit seen_t3;

    clr = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      check("reset_state", int'(dut_rec[i]), 0);
      check("reset_alu", int'(dut_alu[i]), 0);
    end
    clr = 1'b0;
    tick();

    // ldi, MEM_WAIT=1
    start(5'd1);
    d0 = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) tick();
      if (c == 1) begin
        check("t1_T0_state", int'(dut_rec[0].st), 1);
        check("t1_T0_Zin", int'((dut_rec[0].sig & ZIN) != 0), 1);
        check("t1_T0_alu", int'(dut_alu[0]), 12);
      end
      if (c == 7) check("t1_T5_zlo_gra_rin", int'(dut_rec[0].sig & (ZLO | GRA | RIN)), int'(ZLO | GRA | RIN));
      if (c == 9) check("t1_idle_after", int'(dut_rec[0].st), 0);
      if (dut_rec[0].sig[17] && d0 < 0) d0 = c;
    end
    check("t1_done_cycle", d0, 8);

    // ld, MEM_WAIT=3; opcode changed after T3 must be ignored
    start(5'd0);
    d2 = -1; n_rd = 0; rd_run = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      if (c == 8) opc = 5'd1;
      if (dut_rec[2].sig[9]) begin
        n_rd++;
        rd_run++;
      end else begin
        rd_run = 0;
      end
      if (dut_rec[2].sig[6] && dut_rec[2].sig[9]) check("t2_mdrin_on_3rd_read", rd_run, 3);
      if (dut_rec[2].sig[17] && d2 < 0) d2 = c;
    end
    check("t2_read_cycles", n_rd, 6);
    check("t2_done_cycle", d2, 14);

    // st, MEM_WAIT=2
    start(5'd2);
    d1 = -1; n_wr = 0; n_rin = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      if (dut_rec[1].st == 4'd8)
        check("t3_T6_gra_rout_mdrin", int'(dut_rec[1].sig & (GRA | ROUT | MDI)), int'(GRA | ROUT | MDI));
      if (dut_rec[1].sig[10]) n_wr++;
      if (dut_rec[1].sig[13]) n_rin++;
      if (dut_rec[1].sig[17] && d1 < 0) d1 = c;
    end
    check("t3_write_cycles", n_wr, 2);
    check("t3_rin_count", n_rin, 0);
    check("t3_done_cycle", d1, 12);

    // illegal opcode
    start(5'd3);
    n_ill = 0; n_dn = 0; n_bad = 0; seen_t3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (c == 6) check("t4_err_state", int'(dut_rec[0].st), 11);
      if (seen_t3 && (dut_rec[0].sig & (MAI | ZIN)) != 0) n_bad++;
      if (dut_rec[0].st == 4'd5) seen_t3 = 1'b1;
      if (dut_rec[0].sig[18]) n_ill++;
      if (dut_rec[0].sig[17]) n_dn++;
    end
    check("t4_illegal_cycles", n_ill, 1);
    check("t4_done_count", n_dn, 0);
    check("t4_marin_zin_after_T3", n_bad, 0);
    check("t4_idle_after", int'(dut_rec[0].st), 0);

    // clr in the middle of ld T6 (MEM_WAIT=3 instance)
    start(5'd0);
    for (int c = 2; c <= 11; c++) tick();
    check("t5_in_T6", int'(dut_rec[2].st), 8);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("t5_after_clr_outputs", int'(dut_rec[i]), 0);
      check("t5_after_clr_alu", int'(dut_alu[i]), 0);
    end
    n_dn = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dut_rec[2].sig[17]) n_dn++;
    end
    check("t5_no_done_after_clr", n_dn, 0);
    start(5'd0);
    check("t5_restart_T0", int'(dut_rec[2].st), 1);
    for (int c = 0; c < 20; c++) tick();

    // back-to-back ldi with run held
    opc = 5'd1;
    run = 1'b1;
    tick();
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) tick();
      if (d1 > 0 && c == d1 + 1) check("t6_done_to_T0", int'(dut_rec[0].st), 1);
      if (dut_rec[0].sig[17]) begin
        if (d1 < 0) begin
          d1 = c;
        end else if (d2 < 0) begin
          d2 = c;
          run = 1'b0;
        end
      end
    end
    run = 1'b0;
    check("t6_first_done", d1, 8);
    check("t6_done_spacing", d2 - d1, 8);
    for (int c = 0; c < 20; c++) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
